// File: rtl/usb_rx_reader.sv
// FT245 receive-side reader: strobes RD# while rd_req is high and RXF# is low,
// buffers the bytes in a small FIFO and exposes them through a zero-wait Avalon slave.
module usb_rx_reader #(
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter int unsigned RD_LOW_CYCLES  = 4,
  parameter int unsigned RD_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        usb_rxf_n,
  input  logic [7:0]  usb_data,
  output logic        usb_rd_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  localparam int unsigned Depth    = 2 ** DEPTH_LOG2;
  localparam int unsigned TimerMax = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ?
                                     RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  localparam logic [TimerW-1:0]     LowLoad   = TimerW'(RD_LOW_CYCLES - 1);
  localparam logic [TimerW-1:0]     HighLoad  = TimerW'(RD_HIGH_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   CountFull = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {StIdle, StStrobe, StRecover} state_e;

  state_e              r_state, w_state_d;
  logic [TimerW-1:0]   r_timer, w_timer_d;
  logic                r_rd_n, w_rd_n_d;
  logic                r_rxf_meta, r_rxf_s;

  logic [7:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_underflow;

  logic w_push, w_pop_req, w_pop, w_flush, w_empty, w_full;
  logic w_unused;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CountFull);
  assign w_pop_req = chipselect && !read_n && (address == 2'd0);
  assign w_pop     = w_pop_req && !w_empty;
  assign w_flush   = chipselect && !write_n && (address == 2'd2) && writedata[0];
  assign w_unused  = ^writedata[31:1];
  assign usb_rd_n  = r_rd_n;

  // RXF# is asynchronous to clk; both flops idle at "no data".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxf_meta <= 1'b1;
      r_rxf_s    <= 1'b1;
    end else begin
      r_rxf_meta <= usb_rxf_n;
      r_rxf_s    <= r_rxf_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_rd_n  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_rd_n  <= w_rd_n_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_rd_n_d  = r_rd_n;
    w_push    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Full check lives here, so a byte in flight always has a free slot.
        if (rd_req && !r_rxf_s && !w_full) begin
          w_state_d = StStrobe;
          w_timer_d = LowLoad;
          w_rd_n_d  = 1'b0;
        end
      end
      StStrobe: begin
        if (r_timer == '0) begin
          w_push    = 1'b1;
          w_rd_n_d  = 1'b1;
          w_timer_d = HighLoad;
          w_state_d = StRecover;
        end else begin
          w_timer_d = r_timer - TimerW'(1);
        end
      end
      StRecover: begin
        if (r_timer == '0) begin
          w_state_d = StIdle;
        end else begin
          w_timer_d = r_timer - TimerW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= usb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (w_flush) begin
      // Flush overrides any same-cycle push or pop.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_pop_req && w_empty) begin
        r_underflow <= 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[7:0] = w_empty ? 8'h00 : r_mem[r_rd_ptr];
      2'd1: begin
        readdata[DEPTH_LOG2:0] = r_count;
        readdata[16]           = w_empty;
        readdata[17]           = w_full;
        readdata[18]           = (r_state != StIdle);
        readdata[19]           = r_underflow;
        readdata[20]           = rd_req;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_usb_rx_reader.sv
// Bench for usb_rx_reader: directed FT245/Avalon traffic, a queue-based reference
// model checked every cycle, and hand-computed literal expectations.
module tb_usb_rx_reader;

  localparam int DEPTH = 16;
  localparam int LOW   = 4;
  localparam int HIGH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic        usb_rxf_n = 1'b1;
  logic [7:0]  usb_data;
  logic        usb_rd_n;
  logic [1:0]  address = 2'd1;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;

  int vecs = 0;
  int errs = 0;

  usb_rx_reader dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .usb_rxf_n  (usb_rxf_n),
    .usb_data   (usb_data),
    .usb_rd_n   (usb_rd_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  // FT245 side: presents supply[sup_idx], advances when RD# rises.
  logic [7:0] supply [256];
  logic [7:0] sup_idx = 8'd0;
  assign usb_data = supply[sup_idx];
  always @(posedge usb_rd_n) sup_idx <= sup_idx + 8'd1;

  int strobes = 0;
  initial forever begin
    @(negedge usb_rd_n);
    strobes = strobes + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs = vecs + 1;
    if (got !== exp) begin
      errs = errs + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the cycle index of the last strobe start.
  logic [7:0] mq[$];
  bit m_under = 0;
  int m_cyc = 0;
  bit m_started = 0;
  int m_s = 0;
  bit m_h1 = 1, m_h2 = 1;
  bit m_pop, m_flush, m_start, m_cap;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_under = 0; m_cyc = 0; m_started = 0; m_s = 0; m_h1 = 1; m_h2 = 1;
    end else begin
      m_cyc   = m_cyc + 1;
      m_pop   = chipselect && !read_n && address == 2'd0;
      m_flush = chipselect && !write_n && address == 2'd2 && writedata[0];
      m_cap   = m_started && (m_cyc == m_s + LOW);
      m_start = (!m_started || m_cyc >= m_s + LOW + HIGH + 1) && rd_req && !m_h2 &&
                (mq.size() < DEPTH);
      if (m_flush) begin
        mq.delete();
        m_under = 0;
      end else begin
        if (m_pop) begin
          if (mq.size() == 0) m_under = 1;
          else void'(mq.pop_front());
        end
        if (m_cap) mq.push_back(usb_data);
      end
      if (m_start) begin
        m_started = 1;
        m_s = m_cyc;
      end
      m_h2 = m_h1;
      m_h1 = usb_rxf_n;
    end
  end

  logic [31:0] e_rd;
  logic        e_rdn;
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset) begin
      e_rdn = !(m_started && m_cyc >= m_s && m_cyc < m_s + LOW);
      e_rd  = '0;
      if (address == 2'd0) begin
        if (mq.size() != 0) e_rd[7:0] = mq[0];
      end else if (address == 2'd1) begin
        e_rd[4:0] = 5'(mq.size());
        e_rd[16]  = (mq.size() == 0);
        e_rd[17]  = (mq.size() == DEPTH);
        e_rd[18]  = m_started && (m_cyc < m_s + LOW + HIGH);
        e_rd[19]  = m_under;
        e_rd[20]  = rd_req;
      end
      chk("model_rd_n", {31'b0, usb_rd_n}, {31'b0, e_rdn});
      chk("model_readdata", readdata, e_rd);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // All tasks start and end just after a negedge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #2 d = readdata;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; address = 2'd1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = v;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = 2'd1;
  endtask

  task automatic wait_strobes(input int target, input int limit);
    int n = 0;
    while (strobes < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", {31'b0, strobes >= target}, 32'd1);
  endtask

  task automatic low_len(input string name);
    int n = 0;
    while (usb_rd_n == 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, LOW);
  endtask

  logic [31:0] d;
  int s0;

  initial begin
    for (int i = 0; i < 256; i++) supply[i] = 8'hEE;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and rd_req gating.
    chk("rst_rd_n", {31'b0, usb_rd_n}, 32'd1);
    rd(2'd1, d); chk("rst_status", d, 32'h0001_0000);
    s0 = strobes;
    usb_rxf_n = 1'b0;
    tick(50);
    chk("idle_strobes", strobes - s0, 0);
    rd(2'd1, d); chk("idle_status", d, 32'h0001_0000);

    // Single byte 0xA5.
    supply[sup_idx] = 8'hA5;
    s0 = strobes;
    rd_req = 1'b1;
    wait_strobes(s0 + 1, 20);
    rd_req = 1'b0;
    low_len("a5_low_cycles");
    tick(20);
    chk("a5_no_restrobe", strobes - s0, 1);
    rd(2'd1, d); chk("a5_status", d, 32'h0000_0001);
    rd(2'd0, d); chk("a5_data", d, 32'h0000_00A5);
    rd(2'd1, d); chk("a5_empty", d, 32'h0001_0000);

    // Fill to full, then one pop frees one slot.
    for (int k = 0; k < 20; k++) supply[8'(sup_idx + k)] = 8'(k);
    s0 = strobes;
    rd_req = 1'b1;
    tick(16 * 7 + 20);
    chk("fill_strobes", strobes - s0, 16);
    rd(2'd1, d); chk("fill_status", d, 32'h0012_0010);
    tick(30);
    chk("full_hold", strobes - s0, 16);
    chk("full_rd_n", {31'b0, usb_rd_n}, 32'd1);
    rd(2'd0, d); chk("fill_first", d, 32'h0000_0000);
    tick(20);
    chk("refill_strobe", strobes - s0, 17);
    rd_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      rd(2'd0, d); chk("fill_order", d, 32'(k));
    end
    rd(2'd1, d); chk("drained", d, 32'h0001_0000);

    // Pop on the capture edge with five bytes already held.
    for (int k = 0; k < 8; k++) supply[8'(sup_idx + k)] = 8'(8'h20 + k);
    s0 = strobes;
    rd_req = 1'b1;
    wait_strobes(s0 + 6, 60);
    rd_req = 1'b0;
    tick(3);
    rd(2'd0, d); chk("cap_pop_data", d, 32'h0000_0020);
    tick(4);
    rd(2'd1, d); chk("cap_pop_count", d, 32'h0000_0005);
    for (int k = 1; k <= 5; k++) begin
      rd(2'd0, d); chk("cap_pop_order", d, 32'(8'h20 + k));
    end

    // Underflow, flush, flush on the capture edge.
    rd(2'd0, d); chk("under_data", d, 32'h0000_0000);
    rd(2'd1, d); chk("under_flag", d, 32'h0009_0000);
    wr(2'd2, 32'h1);
    rd(2'd1, d); chk("flush_clear", d, 32'h0001_0000);
    supply[sup_idx] = 8'h30;
    s0 = strobes;
    rd_req = 1'b1;
    wait_strobes(s0 + 1, 20);
    rd_req = 1'b0;
    tick(3);
    wr(2'd2, 32'h1);
    tick(4);
    rd(2'd1, d); chk("flush_on_cap", d, 32'h0001_0000);

    // Reset during the second low cycle of RD#.
    supply[sup_idx] = 8'h40;
    supply[8'(sup_idx + 1)] = 8'h41;
    s0 = strobes;
    rd_req = 1'b1;
    wait_strobes(s0 + 1, 20);
    tick(1);
    #1 reset = 1'b1;
    #1 chk("rst_async_rd_n", {31'b0, usb_rd_n}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, d); chk("rst_mid_status", d, 32'h0011_0000);
    s0 = strobes;
    wait_strobes(s0 + 1, 20);
    rd_req = 1'b0;
    low_len("rst_fresh_low");
    tick(5);
    rd(2'd0, d); chk("rst_fresh_data", d, 32'h0000_0041);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
